sprdma_ctrl: RTL and testbench
==============================

# sprdma_ctrl

Sprite-RAM DMA controller and CPU/DMA memory-bus arbiter, placed between the CPU bus and the memory/IO decoder. A CPU write to 0x4014 with page value P stalls the CPU and copies 256 bytes, P00h–PFFh, to the SPR-RAM data port at 0x2004 using alternating read/write bus cycles. When idle, the block passes CPU bus traffic straight through to memory.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- DST_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer. Power of two, ≤256.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr_out  in  16  CPU bus address.
- cpu_data_out  in  8  CPU write data.
- cpu_wen  in  1  CPU write enable.
- cpu_ren  in  1  CPU read enable.
- cpu_data_in  out  8  read data returned to the CPU.
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU must hold its bus.
- mem_addr_out  out  16  address to the memory decoder.
- mem_data_out  out  8  write data to memory.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- mem_data_in  in  8  memory read data, combinational and valid in the same cycle as mem_ren.
- dma_busy  out  1  high from the HALT state through the final WRITE.
- dma_done  out  1  one-cycle pulse in the cycle after the final WRITE.

## Operation
- The FSM has four states: IDLE, HALT, ALIGN, XFER. XFER has a phase bit (RD/WR).
- A parity flop cyc_odd resets to 0 and toggles every cycle.
- IDLE:
  - Combinational pass-through: mem_* = cpu_*, cpu_data_in = mem_data_in, cpu_rdy=1.
  - Trigger: cpu_wen && cpu_addr_out==DMA_REG_ADDR. On the trigger:
    - The write is still forwarded to memory, so the 0x4014 register updates.
    - page ← cpu_data_out, idx ← 0, next state HALT.
- HALT: cpu_rdy=0, mem_wen=mem_ren=0, mem_addr_out=0, mem_data_out=0.
  - If cyc_odd=1, next state is XFER/RD.
  - Otherwise next state is ALIGN.
- ALIGN: same outputs as HALT. Next state XFER/RD.
- XFER/RD: mem_ren=1, mem_addr_out={page,idx}; byte_buf ← mem_data_in at the clock edge. Next state XFER/WR.
- XFER/WR: mem_wen=1, mem_addr_out=DST_ADDR, mem_data_out=byte_buf.
  - If idx==XFER_LEN-1, next state is IDLE and dma_done pulses in the following cycle.
  - Otherwise idx ← idx+1 and next state is XFER/RD.
- Outside IDLE:
  - All cpu_* inputs are ignored and never forwarded.
  - cpu_data_in=0, cpu_rdy=0, dma_busy=1.
- Arithmetic:
  - idx is 8 bits and never wraps within a transfer.
  - The source address is page concatenated with idx; it has no carry into the next page.
  - Any page value 00h–FFh is accepted and no range check is done.
- While busy, a write to DMA_REG_ADDR cannot be observed because cpu_* is ignored. No re-trigger is possible.
- Reset:
  - In any state, rst forces IDLE, idx=0, page=0, byte_buf=0, cyc_odd=0.
  - A transfer in progress is abandoned with no further mem_wen. Bytes already written stay written.

## Timing
- Reset values: cpu_rdy=1, dma_busy=0, dma_done=0, FSM=IDLE. mem_* mirror cpu_* (pass-through).
- Trigger in cycle T:
  - HALT in T+1.
  - The first RD is in T+2 if cyc_odd=1 during HALT, otherwise in T+3.
  - Every RD falls in a cycle with cyc_odd=0.
- Stall length (cpu_rdy=0): 1 + 2·XFER_LEN cycles (513) when HALT is odd, or 2 + 2·XFER_LEN (514) when HALT is even.
- cpu_rdy returns to 1 and dma_done=1 in the cycle after the last WR.
  - The CPU may issue a new bus cycle, including a new trigger, in that same cycle.
- Read-to-write latency: 1 cycle. Data read in RD at cycle k is written in WR at cycle k+1.
- There are no bubbles between byte pairs.

## Test plan
- Preload RAM 0x0200–0x02FF with value = index. Reset, then CPU writes 0x02 to 0x4014.
  - Required: exactly 256 writes to 0x2004 with data 00h…FFh in order.
  - Required: 256 reads at 0x0200…0x02FF, alternating RD/WR with no gaps; dma_done pulses once.
- Trigger with HALT on an odd cycle, then on an even cycle. Required: cpu_rdy low for 513 and 514 cycles respectively; first RD always on cyc_odd=0.
- Idle pass-through: CPU writes 0x5A to 0x0010, then reads 0x0010. Required: mem_* equals cpu_* in the same cycle, cpu_data_in=5Ah, cpu_rdy stays 1.
- During the stall, drive cpu_wen=1 to 0x0010 with data 0xFF. Required: no memory write to 0x0010; RAM value unchanged.
- Assert rst at cycle 100 of a transfer. Required: cpu_rdy=1 and dma_busy=0 in the next cycle, no further 0x2004 writes, no dma_done pulse.
- Page FFh source (ROM 0xFF00–0xFFFF). Required: the last read address is 0xFFFF, with no wrap into page 00h.

Source files
------------

// File: rtl/sprdma_ctrl.sv
// sprdma_ctrl: sprite-RAM DMA engine and CPU/DMA memory-bus arbiter
module sprdma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR     = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr_out,
  output logic [7:0]  mem_data_out,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [7:0]  mem_data_in,
  output logic        dma_busy,
  output logic        dma_done
);
  typedef enum logic [1:0] {IDLE, HALT, ALIGN, XFER} state_t;
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  state_t     state_q;
  logic       wr_q, cyc_odd_q, done_q;
  logic [7:0] page_q, idx_q, byte_buf_q;
  logic       idle, rd, wr, trig;
  assign trig = cpu_wen && cpu_addr_out == DMA_REG_ADDR;
  // FSM: HALT aligns the first read onto an even cycle, then XFER alternates RD/WR per byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      cyc_odd_q  <= 1'b0;
      done_q     <= 1'b0;
      page_q     <= '0;
      idx_q      <= '0;
      byte_buf_q <= '0;
    end else begin
      cyc_odd_q <= ~cyc_odd_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (trig) begin
          page_q  <= cpu_data_out;
          idx_q   <= '0;
          state_q <= HALT;
        end
        HALT: begin
          state_q <= cyc_odd_q ? XFER : ALIGN;
          wr_q    <= 1'b0;
        end
        ALIGN: begin
          state_q <= XFER;
          wr_q    <= 1'b0;
        end
        default: if (!wr_q) begin
          byte_buf_q <= mem_data_in;
          wr_q       <= 1'b1;
        end else if (idx_q == LAST) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          wr_q    <= 1'b0;
        end else begin
          idx_q <= idx_q + 8'd1;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end
  // bus mux: CPU passes straight through when idle, otherwise the DMA owns the bus
  always_comb begin
    idle         = state_q == IDLE;
    rd           = state_q == XFER && !wr_q;
    wr           = state_q == XFER && wr_q;
    mem_addr_out = idle ? cpu_addr_out : rd ? {page_q, idx_q} : wr ? DST_ADDR : 16'h0000;
    mem_data_out = idle ? cpu_data_out : wr ? byte_buf_q : 8'h00;
    mem_wen      = idle ? cpu_wen : wr;
    mem_ren      = idle ? cpu_ren : rd;
    cpu_data_in  = idle ? mem_data_in : 8'h00;
    cpu_rdy      = idle;
    dma_busy     = !idle;
    dma_done     = done_q;
  end
endmodule

// File: tb/tb_sprdma_ctrl.sv
// tb_sprdma_ctrl: randomized self-checking bench against a transfer-level reference model
module tb_sprdma_ctrl;
  localparam int XL = 256;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] cpu_addr_out, mem_addr_out;
  logic [7:0]  cpu_data_out, cpu_data_in, mem_data_out, mem_data_in;
  logic        cpu_wen, cpu_ren, cpu_rdy, mem_wen, mem_ren, dma_busy, dma_done;
  logic [7:0]  ram [0:65535];
  int unsigned cnt;
  int          errors = 0, checks = 0;
  bit          mon = 1'b0;
  int          rd_cyc[$], wr_cyc[$], done_cyc[$];
  logic [15:0] rd_addr[$];
  logic [7:0]  wr_data[$];
  int          stall, stray;

  always #5 clk = ~clk;

  sprdma_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr_out(cpu_addr_out), .cpu_data_out(cpu_data_out),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_data_in(cpu_data_in), .cpu_rdy(cpu_rdy),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_data_in(mem_data_in),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  assign mem_data_in = ram[mem_addr_out];

  // memory model plus a cycle counter whose parity equals the spec's cyc_odd
  always @(posedge clk) begin
    cnt <= rst ? 0 : cnt + 1;
    if (mem_wen && mem_addr_out != 16'h2004) ram[mem_addr_out] <= mem_data_out;
  end

  // bus monitor sampled mid-cycle
  always @(negedge clk) if (mon) begin
    if (mem_ren && !cpu_rdy) begin rd_cyc.push_back(cnt); rd_addr.push_back(mem_addr_out); end
    if (mem_wen && !cpu_rdy && mem_addr_out == 16'h2004) begin wr_cyc.push_back(cnt); wr_data.push_back(mem_data_out); end
    if (dma_done) done_cyc.push_back(cnt);
    if (!cpu_rdy) stall++;
    if (mem_wen && !cpu_rdy && mem_addr_out == 16'h0010) stray++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    rd_cyc.delete(); wr_cyc.delete(); done_cyc.delete(); rd_addr.delete(); wr_data.delete();
    stall = 0; stray = 0;
  endtask

  task automatic idle_bus();
    cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_addr_out = 16'h0300; cpu_data_out = 8'h00;
  endtask

  // one full transfer; want_odd selects HALT parity (-1 = whatever comes)
  task automatic xfer(input logic [7:0] p, input int want_odd, input bit poke);
    int t, k, halt_odd, n, bad_rd, bad_wr, bad_gap;
    clear();
    @(posedge clk); #1;
    while (want_odd >= 0 && int'((cnt + 1) % 2) != want_odd) begin @(posedge clk); #1; end
    mon = 1'b1;
    cpu_wen = 1'b1; cpu_ren = 1'b0; cpu_addr_out = 16'h4014; cpu_data_out = p;
    t = int'(cnt);
    @(posedge clk); #1;
    if (poke) begin
      cpu_wen = 1'b1; cpu_addr_out = 16'h0010; cpu_data_out = 8'hFF;
    end else begin
      cpu_wen = 1'b0; cpu_ren = 1'($urandom); cpu_addr_out = 16'($urandom); cpu_data_out = 8'($urandom);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (!cpu_rdy && k < 1000);
    idle_bus();
    repeat (2) @(negedge clk);
    #1 mon = 1'b0;
    chk("timeout", k < 1000, 1);
    halt_odd = (t + 1) % 2;
    chk("stall_len", stall, halt_odd ? 2 * XL + 1 : 2 * XL + 2);
    chk("rd_count", rd_cyc.size(), XL);
    chk("wr_count", wr_cyc.size(), XL);
    n = rd_cyc.size() < wr_cyc.size() ? rd_cyc.size() : wr_cyc.size();
    bad_rd = 0; bad_wr = 0; bad_gap = 0;
    for (int i = 0; i < n; i++) begin
      bad_rd  += int'(rd_addr[i] != {p, 8'(i)});
      bad_wr  += int'(wr_data[i] != ram[{p, 8'(i)}]);
      bad_gap += int'(wr_cyc[i] != rd_cyc[i] + 1 || (i > 0 && rd_cyc[i] != rd_cyc[i-1] + 2));
    end
    chk("rd_addr_seq", bad_rd, 0);
    chk("wr_data_seq", bad_wr, 0);
    chk("rd_wr_gaps", bad_gap, 0);
    if (rd_cyc.size() > 0) begin
      chk("first_rd_cyc", rd_cyc[0], t + (halt_odd ? 2 : 3));
      chk("first_rd_even", rd_cyc[0] % 2, 0);
      chk("last_rd_addr", rd_addr[rd_addr.size()-1], {p, 8'hFF});
    end
    chk("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0) chk("done_cyc", done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
    chk("reg_4014", ram[16'h4014], p);
    if (poke) begin
      chk("stray_wr", stray, 0);
      chk("ram_0010", ram[16'h0010], 8'h5A);
    end
  endtask

  initial begin
    int n0;
    logic [7:0] p;
    for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] <= 8'(i);
    cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_addr_out = 16'h1234; cpu_data_out = 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rdy", cpu_rdy, 1);
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_pass_addr", mem_addr_out, 16'h1234);
    chk("rst_pass_ren", mem_ren, 1);
    // idle pass-through write then read
    @(posedge clk); #1 cpu_wen = 1'b1; cpu_ren = 1'b0; cpu_addr_out = 16'h0010; cpu_data_out = 8'h5A;
    @(negedge clk);
    chk("pt_wen", mem_wen, 1);
    chk("pt_waddr", mem_addr_out, 16'h0010);
    chk("pt_wdata", mem_data_out, 8'h5A);
    chk("pt_wrdy", cpu_rdy, 1);
    @(posedge clk); #1 cpu_wen = 1'b0; cpu_ren = 1'b1;
    @(negedge clk);
    chk("pt_ren", mem_ren, 1);
    chk("pt_raddr", mem_addr_out, 16'h0010);
    chk("pt_rdata", cpu_data_in, 8'h5A);
    chk("pt_rrdy", cpu_rdy, 1);
    idle_bus();
    // directed transfers: page 02 on odd HALT, poke during even HALT, page FF
    xfer(8'h02, 1, 1'b0);
    xfer(8'($urandom), 0, 1'b1);
    xfer(8'hFF, -1, 1'b0);
    // randomized transfers with random idle gaps
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      xfer(8'($urandom), -1, 1'b0);
    end
    // reset mid-transfer
    clear();
    @(posedge clk); #1;
    mon = 1'b1;
    p = 8'($urandom);
    cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = p;
    @(posedge clk); #1 idle_bus();
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_cpu_rdy", cpu_rdy, 1);
    chk("mrst_busy", dma_busy, 0);
    n0 = wr_cyc.size();
    chk("mrst_some_wr", n0 > 0 && n0 < XL, 1);
    repeat (600) @(negedge clk);
    #1 mon = 1'b0;
    chk("mrst_post_wr", wr_cyc.size(), n0);
    chk("mrst_no_done", done_cyc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
